rv32m_exec_unit: RTL and testbench
==================================

RV32M_EXEC_UNIT -- requirements
Module: rv32m_exec_unit

Interface
REQ-001 Clock and reset: one clock, CLK; reset RST is synchronous and active-high.
REQ-002 CLK  input  1  rising-edge clock.
REQ-003 RST  input  1  synchronous active-high reset.
REQ-004 start  input  1  request from decode/execute; sampled only in IDLE.
REQ-005 op  input  3  rv32m_op_t, funct3 order: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
REQ-006 operand_a  input  32  rs1 value, captured when start is accepted.
REQ-007 operand_b  input  32  rs2 value, captured when start is accepted.
REQ-008 flush  input  1  pipeline kill; aborts any operation in progress.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse; result is valid in that cycle.
REQ-011 result  output  32  final value; held from the done cycle until the next accepted start.

Function
REQ-012 The unit SHALL implement states IDLE, MUL, DIV, FIXUP and DONE.
REQ-013 In IDLE, start=1 with flush=0 SHALL capture op and both operands and move to MUL (op<4) or DIV (op>=4).
REQ-014 Operand-condition check at start acceptance:
- divisor==0, or DIV/REM with a=0x80000000 and b=0xFFFFFFFF: SHALL go directly to FIXUP.
- Each of these cases takes 0 iterations.
REQ-015 MUL state: 32 radix-2 shift-add iterations, one per cycle, on operand magnitudes, producing a 64-bit product. Sign handling:
- MUL, MULH: both operands signed.
- MULHSU: a signed, b unsigned.
- MULHU: both unsigned.
REQ-016 DIV state: 32 restoring-division iterations, one per cycle, on magnitudes. DIV and REM are signed; DIVU and REMU are unsigned.
REQ-017 A 5-bit iteration counter SHALL count 0..31; FIXUP SHALL be entered on the edge that completes iteration 31.
REQ-018 FIXUP (one cycle) SHALL apply signs and select the result.
- Product sign = sign(a) XOR sign(b) over the signed operands.
- MUL selects product[31:0]; MULH, MULHSU and MULHU select product[63:32].
- Quotient sign = sign(a) XOR sign(b); remainder takes the sign of the dividend.
- Divide by zero: quotient = 0xFFFFFFFF, remainder = a.
- Overflow case: quotient = 0x80000000, remainder = 0.
REQ-019 DONE SHALL assert done for exactly one cycle, load result, then return to IDLE.
REQ-020 Latency, with the start-accept edge as cycle 0:
- Normal operations: done visible in cycle 34.
- Zero-iteration cases: done visible in cycle 2.
REQ-021 start while busy SHALL be ignored; no queuing.
REQ-022 flush in any non-IDLE state SHALL force IDLE on the next edge. No done is produced and result is left unchanged.
REQ-023 start and flush in the same IDLE cycle: flush wins and start is ignored.
REQ-024 flush in the DONE cycle: done still asserts and result still updates, because the operation has already completed.
REQ-025 The iteration counter and internal arithmetic SHALL never wrap beyond 32 iterations; the adder SHALL be 33 bits wide.

Reset
REQ-026 RST=1 at any edge, including mid-operation, SHALL force IDLE with busy=0, done=0, result=0 and counter=0, and SHALL clear the captured operands.
REQ-027 While RST=1, start SHALL be ignored.

Structure
REQ-028 rv32m_op_t SHALL live in rv32m_pkg, alongside the existing RV32M decode types. The FSM state enum SHALL be local to the module.
REQ-029 A single sub-module, rv32m_sign_fixup (combinational, applying the REQ-018 rules), is natural; everything else SHALL reside in rv32m_exec_unit.

Verification
REQ-030 MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, done in cycle 34, busy high in cycles 1-33.
REQ-031 High-half multiplies:
- MULH 0x80000000 x 0x80000000 -> 0x40000000.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-032 Signed divide: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM of the same operands -> 0xFFFFFFFF.
REQ-033 Divide by zero: DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, both with done in cycle 2.
REQ-034 Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, both with done in cycle 2.
REQ-035 flush and interruption:
- flush asserted in cycle 10 of a DIV -> busy=0 in cycle 11, no done, result unchanged; a new start in cycle 11 completes normally.
- RST asserted in cycle 10 -> all outputs 0 in cycle 11.

Source files
------------

// File: rtl/rv32m_pkg.sv
// Shared RV32M types: R-type decode layout, M-extension operation codes and
// small operand-classification helpers used by the execute unit.
package rv32m_pkg;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } rv32_rtype_t;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } rv32m_op_t;

  function automatic logic is_div_op(input rv32m_op_t op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic op_a_signed(input rv32m_op_t op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_b_signed(input rv32m_op_t op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

  function automatic logic div_by_zero(input rv32m_op_t op, input logic [31:0] b);
    return is_div_op(op) && (b == '0);
  endfunction

  function automatic logic div_overflow(input rv32m_op_t op, input logic [31:0] a,
                                        input logic [31:0] b);
    return (op inside {OP_DIV, OP_REM}) && (a == 32'h8000_0000) && (b == '1);
  endfunction

endpackage

// File: rtl/rv32m_sign_fixup.sv
// Combinational result stage: restores operand signs on the magnitude
// product/quotient/remainder and substitutes the divide special cases.
module rv32m_sign_fixup
  import rv32m_pkg::*;
(
  input  rv32m_op_t   op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [31:0] acc_hi,
  input  logic [31:0] acc_lo,
  output logic [31:0] result
);

  logic        neg_a;
  logic        neg_b;
  logic [63:0] product;
  logic [31:0] quotient;
  logic [31:0] remainder;

  always_comb begin
    neg_a     = op_a_signed(op) && operand_a[31];
    neg_b     = op_b_signed(op) && operand_b[31];
    product   = (neg_a ^ neg_b) ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    quotient  = (neg_a ^ neg_b) ? -acc_lo : acc_lo;
    remainder = neg_a ? -acc_hi : acc_hi;
    if (div_by_zero(op, operand_b)) begin
      quotient  = '1;
      remainder = operand_a;
    end else if (div_overflow(op, operand_a, operand_b)) begin
      quotient  = 32'h8000_0000;
      remainder = '0;
    end
    result = '0;
    case (op)
      OP_MUL:                        result = product[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  result = product[63:32];
      OP_DIV, OP_DIVU:               result = quotient;
      OP_REM, OP_REMU:               result = remainder;
      default:                       result = '0;
    endcase
  end

endmodule

// File: rtl/rv32m_exec_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and
// restoring divide on magnitudes, followed by a one-cycle sign fixup.
module rv32m_exec_unit
  import rv32m_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  rv32m_op_t   op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP, S_DONE} state_t;

  state_t      state, state_next;
  rv32m_op_t   op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] acc_hi, acc_lo, divisor;
  logic [4:0]  cnt;
  logic [31:0] fixup_result;
  logic        accept, zero_iter, sub, borrow;
  logic [31:0] mag_a, mag_b;
  logic [32:0] add_x, add_y, sum, mul_hi;

  assign accept    = (state == S_IDLE) && start && !flush;
  assign zero_iter = div_by_zero(op, operand_b) || div_overflow(op, operand_a, operand_b);
  assign mag_a     = (op_a_signed(op) && operand_a[31]) ? -operand_a : operand_a;
  assign mag_b     = (op_b_signed(op) && operand_b[31]) ? -operand_b : operand_b;

  // One 33-bit adder serves both loops: MUL adds the multiplicand into the
  // high half, DIV subtracts the divisor from the shifted partial remainder.
  assign sub    = (state == S_DIV);
  assign add_x  = sub ? {acc_hi, acc_lo[31]} : {1'b0, acc_hi};
  assign add_y  = sub ? ~{1'b0, divisor} : {1'b0, divisor};
  assign sum    = add_x + add_y + {32'b0, sub};
  assign borrow = sum[32];
  assign mul_hi = acc_lo[0] ? sum : {1'b0, acc_hi};

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:         if (accept) state_next = zero_iter ? S_FIXUP
                                             : (is_div_op(op) ? S_DIV : S_MUL);
      S_MUL, S_DIV:   if (flush) state_next = S_IDLE;
                      else if (cnt == 5'd31) state_next = S_FIXUP;
      S_FIXUP:        state_next = flush ? S_IDLE : S_DONE;
      S_DONE:         state_next = S_IDLE;
      default:        state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      op_q    <= OP_MUL;
      a_q     <= '0;
      b_q     <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      divisor <= '0;
      cnt     <= '0;
      result  <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: if (accept) begin
          op_q    <= op;
          a_q     <= operand_a;
          b_q     <= operand_b;
          acc_hi  <= '0;
          acc_lo  <= mag_a;
          divisor <= mag_b;
          cnt     <= '0;
        end
        S_MUL: if (!flush) begin
          acc_hi <= mul_hi[32:1];
          acc_lo <= {mul_hi[0], acc_lo[31:1]};
          if (cnt != 5'd31) cnt <= cnt + 5'd1;
        end
        S_DIV: if (!flush) begin
          acc_hi <= borrow ? add_x[31:0] : sum[31:0];
          acc_lo <= {acc_lo[30:0], ~borrow};
          if (cnt != 5'd31) cnt <= cnt + 5'd1;
        end
        S_FIXUP: if (!flush) result <= fixup_result;
        default: ;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  rv32m_sign_fixup u_sign_fixup (
    .op        (op_q),
    .operand_a (a_q),
    .operand_b (b_q),
    .acc_hi    (acc_hi),
    .acc_lo    (acc_lo),
    .result    (fixup_result)
  );

endmodule

// File: tb/tb_rv32m_exec_unit.sv
// Self-checking bench for rv32m_exec_unit: directed corner cases plus random
// operations checked against a 64-bit arithmetic reference model.
module tb_rv32m_exec_unit;
  import rv32m_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic        flush;
  rv32m_op_t   op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] last_exp;

  always #5 CLK = ~CLK;

  rv32m_exec_unit dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  function automatic logic [31:0] ref_result(input rv32m_op_t o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'h0, a};
    ub = {32'h0, b};
    p  = 0;
    case (o)
      OP_MUL:    p = sa * sb;
      OP_MULH:   p = (sa * sb) >>> 32;
      OP_MULHSU: p = (sa * ub) >>> 32;
      OP_MULHU:  p = (ua * ub) >> 32;
      OP_DIV:    p = (b == 0) ? -1 : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? sa : sa / sb;
      OP_REM:    p = (b == 0) ? sa : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 0 : sa % sb;
      OP_DIVU:   p = (b == 0) ? -1 : ua / ub;
      OP_REMU:   p = (b == 0) ? ua : ua % ub;
      default:   p = 0;
    endcase
    return p[31:0];
  endfunction

  function automatic int unsigned ref_latency(input rv32m_op_t o, input logic [31:0] a,
                                              input logic [31:0] b);
    bit div_op;
    div_op = (o == OP_DIV || o == OP_DIVU || o == OP_REM || o == OP_REMU);
    if (div_op && b == 0) return 2;
    if ((o == OP_DIV || o == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Call at a negedge; returns at the negedge of cycle 1 (start accepted at the edge between).
  task automatic issue(input rv32m_op_t o, input logic [31:0] a, input logic [31:0] b);
    op        = o;
    operand_a = a;
    operand_b = b;
    start     = 1'b1;
    @(negedge CLK);
    start     = 1'b0;
  endtask

  task automatic run_check(input string tag, input rv32m_op_t o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
    int unsigned lat, seen, busy_bad;
    lat      = ref_latency(o, a, b);
    seen     = 0;
    busy_bad = 0;
    issue(o, a, b);
    for (int unsigned k = 1; k <= 40; k++) begin
      if (done === 1'b1) begin
        seen = k;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
      // a second request while busy must be dropped
      if (k == 5) begin
        op        = rv32m_op_t'($urandom_range(0, 7));
        operand_a = $urandom;
        operand_b = $urandom;
        start     = 1'b1;
      end
      if (k == 6) start = 1'b0;
      @(negedge CLK);
    end
    start = 1'b0;
    check({tag, " latency"}, seen, lat);
    check({tag, " busy_before_done"}, busy_bad, 0);
    check({tag, " result"}, result, exp);
    last_exp = exp;
    @(negedge CLK);
    check({tag, " done_one_cycle"}, {31'b0, done}, 0);
    check({tag, " idle_after"}, {31'b0, busy}, 0);
    check({tag, " result_held"}, result, exp);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rv32m_op_t   ro;
    logic [31:0] ra, rb;
    RST = 1'b1; start = 1'b0; flush = 1'b0;
    op = OP_MUL; operand_a = '0; operand_b = '0;
    last_exp = '0;
    repeat (3) @(negedge CLK);
    check("reset busy", {31'b0, busy}, 0);
    check("reset done", {31'b0, done}, 0);
    check("reset result", result, 0);
    RST = 1'b0;
    @(negedge CLK);

    run_check("mul_neg",    OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_check("mulh_min",   OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_check("mulhu_max",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_check("mulhsu_m1",  OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_check("div_neg",    OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    run_check("rem_neg",    OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    run_check("divu_zero",  OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF);
    run_check("remu_zero",  OP_REMU,   32'd5,         32'd0,         32'd5);
    run_check("div_ovf",    OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_check("rem_ovf",    OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

    // flush in cycle 10 of a divide, then a fresh start in cycle 11
    issue(OP_DIV, 32'd1000, 32'd7);
    repeat (9) @(negedge CLK);
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    check("flush busy", {31'b0, busy}, 0);
    check("flush done", {31'b0, done}, 0);
    check("flush result", result, last_exp);
    run_check("after_flush", OP_DIVU, 32'd1000, 32'd7, 32'd142);

    // flush while in the fixup cycle of a zero-iteration op
    issue(OP_DIVU, 32'd9, 32'd0);
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    check("flush_fixup busy", {31'b0, busy}, 0);
    check("flush_fixup done", {31'b0, done}, 0);
    check("flush_fixup result", result, last_exp);

    // flush during the done cycle does not cancel the completed op
    issue(OP_REMU, 32'd9, 32'd0);
    @(negedge CLK);
    flush = 1'b1;
    check("flush_done done", {31'b0, done}, 1);
    check("flush_done result", result, 32'd9);
    last_exp = 32'd9;
    @(negedge CLK);
    flush = 1'b0;
    check("flush_done idle", {31'b0, busy}, 0);
    check("flush_done held", result, 32'd9);

    // start and flush together in idle: flush wins
    op = OP_MUL; operand_a = 32'd3; operand_b = 32'd4;
    start = 1'b1; flush = 1'b1;
    @(negedge CLK);
    start = 1'b0; flush = 1'b0;
    check("start_flush busy", {31'b0, busy}, 0);
    @(negedge CLK);
    check("start_flush done", {31'b0, done}, 0);

    // reset in cycle 10 of a divide clears everything; start under reset is ignored
    issue(OP_DIV, 32'h1234_5678, 32'd3);
    repeat (9) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("rst_mid busy", {31'b0, busy}, 0);
    check("rst_mid done", {31'b0, done}, 0);
    check("rst_mid result", result, 0);
    last_exp = '0;
    op = OP_MUL; operand_a = 32'd5; operand_b = 32'd6; start = 1'b1;
    @(negedge CLK);
    start = 1'b0; RST = 1'b0;
    check("rst_start busy", {31'b0, busy}, 0);
    @(negedge CLK);
    check("rst_start idle", {31'b0, busy}, 0);

    for (int i = 0; i < 40; i++) begin
      ro = rv32m_op_t'($urandom_range(0, 7));
      ra = pick_operand();
      rb = pick_operand();
      run_check($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, ref_result(ro, ra, rb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
